// File: rtl/rvv_pkg.sv
// Shared types and helpers for the rvv_alu issue/collect sequencer.
package rvv_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    // Operand-source encodings shared with the ALU decode
    localparam logic [2:0] VV = 3'b001;
    localparam logic [2:0] VX = 3'b010;
    localparam logic [2:0] VI = 3'b100;

    // Number of lane chunks that make up one SEW-wide element
    function automatic int unsigned steps_per_elem(input logic [2:0] vsew,
                                                   input int unsigned lane_width);
        return 32'd1 << (32'(vsew) + 32'd3 - lane_width);
    endfunction

    // Elements of width 8<<vsew that fit in one vector register
    function automatic int unsigned vlmax(input logic [2:0] vsew,
                                          input int unsigned vlen);
        return vlen >> (32'(vsew) + 32'd3);
    endfunction

endpackage

// File: rtl/rvv_wb_buffer.sv
// Destination-register assembly buffer: VLEN data plus byte mask.
// Supports clear, chunk write at an arbitrary bit index and tail fill.
// Build option RVV_ALU_SEQ_TAIL_AGNOSTIC_EN: tail bytes become 0xFF and
// the mask is all ones; otherwise tail bytes are 0 and unmasked.
module rvv_wb_buffer #(
    parameter int unsigned VLEN       = 128,
    parameter int unsigned LANE_WIDTH = 3,
    localparam int unsigned CW        = 1 << LANE_WIDTH,
    localparam int unsigned NB        = VLEN / 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            clear,
    input  logic            wr_en,
    input  logic [9:0]      wr_index,
    input  logic [CW-1:0]   wr_chunk,
    input  logic            fill_en,
    input  logic [15:0]     tail_start,
    output logic [VLEN-1:0] data,
    output logic [NB-1:0]   mask
);

    localparam logic [VLEN-1:0] ONE_V      = VLEN'(1);
    localparam logic [NB-1:0]   ONE_B      = NB'(1);
    localparam logic [VLEN-1:0] CHUNK_ONES = VLEN'((65'd1 << CW) - 65'd1);

    logic [VLEN-1:0] data_q, data_nxt;
    logic [NB-1:0]   mask_q, mask_nxt;
    logic [VLEN-1:0] chunk_bits, tail_bits;
    logic [NB-1:0]   chunk_bytes, tail_bytes;
    int unsigned     first_b, last_b;

    // Next buffer contents: chunk write first, then tail fill overrides tail bytes
    always_comb begin
        first_b     = 32'(wr_index) >> 3;
        last_b      = (32'(wr_index) + CW - 32'd1) >> 3;
        chunk_bits  = CHUNK_ONES << wr_index;
        chunk_bytes = ((ONE_B << (last_b - first_b + 32'd1)) - ONE_B) << first_b;
        // Shifts past the top yield 0, so an oversized tail_start selects no tail
        tail_bytes  = ~((ONE_B << tail_start) - ONE_B);
        tail_bits   = ~((ONE_V << (32'(tail_start) * 32'd8)) - ONE_V);
        data_nxt    = data_q;
        mask_nxt    = mask_q;
        if (clear) begin
            data_nxt = '0;
            mask_nxt = '0;
        end else begin
            if (wr_en && (32'(wr_index) <= VLEN - CW)) begin
                data_nxt = (data_nxt & ~chunk_bits) | (VLEN'(wr_chunk) << wr_index);
                mask_nxt = mask_nxt | chunk_bytes;
            end
            if (fill_en) begin
`ifdef RVV_ALU_SEQ_TAIL_AGNOSTIC_EN
                data_nxt = data_nxt | tail_bits;
                mask_nxt = '1;
`else
                data_nxt = data_nxt & ~tail_bits;
                mask_nxt = mask_nxt & ~tail_bytes;
`endif
            end
        end
    end

    // Buffer registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q <= '0;
            mask_q <= '0;
        end else begin
            data_q <= data_nxt;
            mask_q <= mask_nxt;
        end
    end

    assign data = data_q;
    assign mask = mask_q;

endmodule

// File: rtl/rvv_alu_seq.sv
// Issue-side sequencer and result collector for one rvv_alu lane.
// Tail policy selected by RVV_ALU_SEQ_TAIL_AGNOSTIC_EN (see rvv_wb_buffer).
module rvv_alu_seq
    import rvv_pkg::*;
#(
    parameter int unsigned VLEN       = 128,
    parameter int unsigned LANE_WIDTH = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [2:0]        vsew,
    input  logic [9:0]        vl,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              alu_run,
    output logic [9:0]        byte_i,
    output logic [3:0]        in_reg_offset,
    input  logic [63:0]       alu_vd,
    input  logic [9:0]        alu_index,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [VLEN-1:0]   wb_data,
    output logic [VLEN/8-1:0] wb_mask
);

    localparam int unsigned CW = 1 << LANE_WIDTH;

    state_t      state, state_nxt;
    logic [2:0]  sew_q;
    logic [9:0]  vl_eff_q, byte_q;
    logic [3:0]  off_q;
    logic        err_q, done0_q;
    logic        bad_sew, accept, last_off, last_chunk;
    int unsigned vlmax_in, steps_q;
    logic [9:0]  vl_eff_in;
    logic        unused_vd;

    // Request decode: legality, clamped element count, and chunk position
    always_comb begin
        bad_sew    = (vsew > 3'd3) || ((32'(vsew) + 32'd3) < LANE_WIDTH);
        vlmax_in   = bad_sew ? 32'd0 : vlmax(vsew, VLEN);
        vl_eff_in  = (32'(vl) < vlmax_in) ? vl : 10'(vlmax_in);
        accept     = (state == IDLE) && start && !bad_sew && (vl_eff_in != 10'd0);
        steps_q    = steps_per_elem(sew_q, LANE_WIDTH);
        last_off   = (32'(off_q) == steps_q - 32'd1);
        last_chunk = (state == RUN) && last_off && (byte_q == vl_eff_q - 10'd1);
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_chunk) state_nxt = WB;
            WB:      if (wb_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, latched request, chunk counters and one-shot pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            sew_q    <= '0;
            vl_eff_q <= '0;
            byte_q   <= '0;
            off_q    <= '0;
            err_q    <= 1'b0;
            done0_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            err_q   <= (state == IDLE) && start && bad_sew;
            done0_q <= (state == IDLE) && start && !bad_sew && (vl_eff_in == 10'd0);
            if (accept) begin
                sew_q    <= vsew;
                vl_eff_q <= vl_eff_in;
                byte_q   <= '0;
                off_q    <= '0;
            end else if (state == RUN) begin
                if (last_chunk) begin
                    byte_q <= '0;
                    off_q  <= '0;
                end else if (last_off) begin
                    byte_q <= byte_q + 10'd1;
                    off_q  <= '0;
                end else begin
                    off_q <= off_q + 4'd1;
                end
            end
        end
    end

    rvv_wb_buffer #(
        .VLEN       (VLEN),
        .LANE_WIDTH (LANE_WIDTH)
    ) u_buf (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (accept),
        .wr_en      (state == RUN),
        .wr_index   (alu_index),
        .wr_chunk   (alu_vd[CW-1:0]),
        .fill_en    (last_chunk),
        .tail_start (16'(vl_eff_q) << sew_q),
        .data       (wb_data),
        .mask       (wb_mask)
    );

    assign unused_vd     = ^alu_vd[63:CW];
    assign busy          = (state != IDLE);
    assign alu_run       = (state == RUN);
    assign wb_valid      = (state == WB);
    assign done          = done0_q | ((state == WB) && wb_ready);
    assign err           = err_q;
    assign byte_i        = byte_q;
    assign in_reg_offset = off_q;

endmodule
